// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
// Pure declarations: no latency, no backpressure.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Level counters need one bit beyond the pointer width so full and empty differ.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Core-side byte push bus plus status and serial line of the buffered UART transmitter.
// Latency/backpressure are set by the attached transmitter; rdy_o low means a write is dropped.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = level_width(FIFO_DEPTH);

  logic                      wr_i;
  logic [UART_DATA_BITS-1:0] wr_data_i;
  logic                      rdy_o;
  logic [LVL_W-1:0]          fifo_level_o;
  logic                      busy_o;
  logic                      tx_o;

  modport master (
    output wr_i, wr_data_i,
    input  rdy_o, fifo_level_o, busy_o, tx_o
  );

  modport slave (
    input  wr_i, wr_data_i,
    output rdy_o, fifo_level_o, busy_o, tx_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered push/pop; head word visible combinationally on pop_dat.
// Level updates one edge after a push/pop; pushes while full are dropped, pops while empty ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = level_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign pop_dat = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and leave LSB-first on tx_o at CLK_DIV clocks/bit.
// Byte written into an idle, empty block is popped next edge and tx_o falls the edge after; rdy_o low = FIFO full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_tx_fifo_if.slave   bus
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_DIV must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam int LW = level_width(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic [LW-1:0]             fifo_level;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (bus.wr_i),
    .push_dat (bus.wr_data_i),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  uart_tx_state_t            state,    state_nxt;
  logic [BW-1:0]             baud_cnt, baud_nxt;
  logic [IW-1:0]             bit_idx,  idx_nxt;
  logic                      stop_cnt, stop_nxt;
  logic [UART_DATA_BITS-1:0] shreg,    shreg_nxt;
  logic                      tx_q,     tx_nxt;
  logic                      busy_q,   busy_nxt;
  logic                      baud_done;

  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      stop_cnt <= stop_nxt;
      shreg    <= shreg_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    stop_nxt  = stop_cnt;
    shreg_nxt = shreg;
    fifo_pop  = 1'b0;

    if (state != IDLE) begin
      baud_nxt = baud_done ? BAUD_MAX : baud_cnt - 1'b1;
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_nxt = fifo_head;
          baud_nxt  = BAUD_MAX;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_done) begin
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == IDX_LAST) begin
            stop_nxt  = 1'b0;
            state_nxt = STOP;
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (stop_cnt != STOP_LAST) begin
            stop_nxt = stop_cnt + 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            fifo_pop  = 1'b1;
            shreg_nxt = fifo_head;
            state_nxt = START;
          end else begin
            baud_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level and busy are registered from the current state, one edge behind it.
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[bit_idx];
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state != IDLE) || !fifo_empty;
  end

  assign bus.rdy_o        = !fifo_full;
  assign bus.fifo_level_o = fifo_level;
  assign bus.busy_o       = busy_q;
  assign bus.tx_o         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) share one stimulus stream and are
// compared every cycle against a frame-timeline reference model, plus a serial-line byte decoder.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int L_A   = 10 * D;
  localparam int L_B   = 11 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_b ();

  assign bus_b.wr_i      = bus_a.wr_i;
  assign bus_b.wr_data_i = bus_a.wr_data_i;

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a.slave)
  );

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  logic       o_tx   [2];
  logic       o_busy [2];
  logic       o_rdy  [2];
  logic [2:0] o_lvl  [2];

  assign o_tx[0]   = bus_a.tx_o;
  assign o_tx[1]   = bus_b.tx_o;
  assign o_busy[0] = bus_a.busy_o;
  assign o_busy[1] = bus_b.busy_o;
  assign o_rdy[0]  = bus_a.rdy_o;
  assign o_rdy[1]  = bus_b.rdy_o;
  assign o_lvl[0]  = bus_a.fifo_level_o;
  assign o_lvl[1]  = bus_b.fifo_level_o;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the edge at which the current frame was popped.
  int         t = 0;
  logic [7:0] m_buf  [2][64];
  logic [7:0] m_log  [2][1024];
  int         m_head [2];
  int         m_tail [2];
  int         m_lp   [2];
  int         m_logn [2];
  bit         m_act  [2];
  logic [7:0] m_cur  [2];
  logic       e_tx   [2];
  logic       e_busy [2];
  int         e_lvl  [2];
  int         mlen, msz, mk;
  bit         mpop;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mlen = (d == 0) ? L_A : L_B;
      if (rst) begin
        if (m_act[d] && t <= m_lp[d] + mlen) m_logn[d]--;
        m_head[d] = 0;
        m_tail[d] = 0;
        m_act[d]  = 1'b0;
        e_tx[d]   = 1'b1;
        e_busy[d] = 1'b0;
        e_lvl[d]  = 0;
      end else begin
        msz       = m_tail[d] - m_head[d];
        e_busy[d] = (msz > 0) || (m_act[d] && t > m_lp[d] && t <= m_lp[d] + mlen);
        mpop      = (msz > 0) && (!m_act[d] || t >= m_lp[d] + mlen);
        if (bus_a.wr_i && msz < DEPTH) begin
          m_buf[d][m_tail[d] % 64] = bus_a.wr_data_i;
          m_tail[d]++;
        end
        if (mpop) begin
          m_cur[d] = m_buf[d][m_head[d] % 64];
          m_head[d]++;
          m_lp[d]  = t;
          m_act[d] = 1'b1;
          m_log[d][m_logn[d] % 1024] = m_cur[d];
          m_logn[d]++;
        end
        e_lvl[d] = m_tail[d] - m_head[d];
        e_tx[d]  = 1'b1;
        if (m_act[d] && t > m_lp[d] && t <= m_lp[d] + mlen) begin
          mk = (t - m_lp[d] - 1) / D;
          if (mk == 0)      e_tx[d] = 1'b0;
          else if (mk <= 8) e_tx[d] = m_cur[d][mk-1];
        end
      end
    end
    t++;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tx%0d", d),    32'(o_tx[d]),   32'(e_tx[d]));
      check($sformatf("busy%0d", d),  32'(o_busy[d]), 32'(e_busy[d]));
      check($sformatf("level%0d", d), 32'(o_lvl[d]),  32'(e_lvl[d]));
      check($sformatf("rdy%0d", d),   32'(o_rdy[d]),  32'(e_lvl[d] < DEPTH));
    end
  end

  // Serial decoder: samples mid-bit, shifts LSB-first, compares each byte with the model's pop log.
  bit         rx_in  [2];
  int         rx_cnt [2];
  logic [7:0] rx_sh  [2];
  int         rx_n   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rx_in[d] = 1'b0;
      end else if (!rx_in[d]) begin
        if (o_tx[d] === 1'b0) begin
          rx_in[d]  = 1'b1;
          rx_cnt[d] = 0;
        end
      end else begin
        rx_cnt[d]++;
        if (rx_cnt[d] % D == D / 2 && rx_cnt[d] < 9 * D)
          rx_sh[d] = {o_tx[d], rx_sh[d][7:1]};
        if (rx_cnt[d] == 9 * D + D / 2) begin
          check($sformatf("rx_stop%0d", d), 32'(o_tx[d]), 32'd1);
          check($sformatf("rx_byte%0d", d), 32'(rx_sh[d]), 32'(m_log[d][rx_n[d] % 1024]));
          rx_n[d]++;
          rx_in[d] = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit w, input logic [7:0] dat);
    @(negedge clk);
    bus_a.wr_i      = w;
    bus_a.wr_data_i = dat;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  initial begin
    int n;
    bus_a.wr_i      = 1'b0;
    bus_a.wr_data_i = 8'h00;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);

    drive(1'b1, 8'h55);
    idle(60);

    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    idle(100);

    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
    idle(5 * L_B + 20);

    // Reset lands during data bit 3 of 0xF0 with two bytes still queued.
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    idle(16);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(60);

    drive(1'b1, 8'h00);
    drive(1'b1, 8'h81);
    idle(100);

    for (int blk = 0; blk < 6; blk++) begin
      int p;
      p = $urandom_range(0, 9);
      repeat (500) drive($urandom_range(0, 9) < p, 8'($urandom));
    end

    n = 0;
    while ((o_busy[0] !== 1'b0 || o_busy[1] !== 1'b0) && n < 2000) begin
      drive(1'b0, 8'h00);
      n++;
    end
    check("drain_in_time", 32'(n < 2000), 32'd1);
    idle(5);
    for (int d = 0; d < 2; d++)
      check($sformatf("rx_count%0d", d), 32'(rx_n[d]), 32'(m_logn[d]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
